sram_arbiter: RTL
=================

# sram_arbiter

Arbitrates the IF-stage instruction SRAM port and the MEM-stage data SRAM port onto one shared single-ported memory interface. It sits between the pipeline and the unified memory. It serialises the two requests with data having priority, captures read data, and raises a stall request to the pipeline controller until every pending access in the current pipeline cycle has completed. A watchdog aborts any access the memory never acknowledges.

## Interface
- `TIMEOUT_CYC`, default 255: maximum number of cycles `mem_req` may wait for `mem_ack` before the access is aborted. Range 1..255.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inst_sram_en` input 1: instruction access pending (IF `inst_sram_en`).
- `inst_sram_wen` input 4: byte write enables; always 0 from IF, passed through.
- `inst_sram_addr` input 32: instruction address (IF pc).
- `inst_sram_wdata` input 32: instruction write data, passed through.
- `inst_sram_rdata` output 32: registered instruction read data.
- `data_sram_en` input 1: data access pending.
- `data_sram_wen` input 4: byte write enables; nonzero means write.
- `data_sram_addr` input 32: data address.
- `data_sram_wdata` input 32: store data.
- `data_sram_rdata` output 32: registered load data.
- `mem_req` output 1: shared-port request, held until ack or timeout.
- `mem_wen` output 4: shared-port byte write enables.
- `mem_addr` output 32: shared-port address.
- `mem_wdata` output 32: shared-port write data.
- `mem_ack` input 1: access complete this cycle; `mem_rdata` is valid when high.
- `mem_rdata` input 32: shared-port read data.
- `stallreq` output 1: to the pipeline controller; high means freeze the pipeline.
- `mem_err` output 1: one-cycle pulse when an access is aborted on timeout.

## Operation
- Flags `inst_done` and `data_done` mark which accesses of the current pipeline cycle are already served.
- `stallreq` is combinational: `stallreq = (inst_sram_en & ~inst_done) | (data_sram_en & ~data_done)`.
- When `stallreq` is 0 at a clock edge, both done flags clear on that edge, because the pipeline advances.
- FSM states are IDLE, DATA, INST.
- IDLE transitions:
  - If `data_sram_en & ~data_done`, latch the data request and go to DATA.
  - Else, if `inst_sram_en & ~inst_done`, latch the instruction request and go to INST.
  - Data always wins a simultaneous request.
- DATA and INST drive `mem_req=1` with the latched wen, addr and wdata, all stable for the whole state.
- On `mem_ack` in either state:
  - If the latched wen is 0, capture `mem_rdata` into the matching rdata register.
  - Set the matching done flag.
  - Clear the watchdog and return to IDLE.
  - No back-to-back issue: IDLE re-evaluates on the next cycle.
- Watchdog:
  - An 8-bit counter increments every cycle in DATA or INST without `mem_ack`.
  - When it reaches `TIMEOUT_CYC` without ack, `mem_err` pulses for one cycle, the matching rdata register loads 0, the done flag sets, and the FSM returns to IDLE.
- Writes leave the rdata registers unchanged.
- Input changes while in DATA or INST have no effect on the shared port until the FSM returns to IDLE.

## Timing
- Reset values: state IDLE, `mem_req=0`, `mem_wen=0`, `mem_addr=0`, `mem_wdata=0`, both rdata registers 0, both done flags 0, `mem_err=0`, watchdog 0.
- Access latency, with the request visible at edge N:
  - `mem_req` is high from cycle N+1.
  - With ack in the same cycle N+1, the rdata register and done flag update at edge N+2.
- Timings after a request is visible:
  - Single access with zero-wait ack: `stallreq` high for 2 cycles.
  - Data plus instruction together: 4 cycles.
- `rst` during DATA or INST:
  - The access is abandoned, and `mem_req` is 0 in the cycle after the reset edge.
  - A `mem_ack` arriving later in IDLE is ignored.
- `mem_ack` while in IDLE is ignored.

## Configuration
- `SRAM_ARB_ADDR_MAP_EN` defined: `mem_addr` is the MIPS fixed mapping of the latched address.
  - kseg0/kseg1 (`0x8000_0000`–`0xBFFF_FFFF`): top 3 bits cleared.
  - All other addresses: passed unchanged.
- `SRAM_ARB_ADDR_MAP_EN` undefined: `mem_addr` equals the latched virtual address.

## Test plan
- Reset release, `inst_sram_en=1`, addr `0xBFC0_0000`, ack on first `mem_req` cycle with rdata `0x2408_0001`:
  - `mem_req` high 1 cycle.
  - `mem_addr` is `0x1FC0_0000` with the macro, `0xBFC0_0000` without.
  - `inst_sram_rdata=0x2408_0001`.
  - `stallreq` high exactly 2 cycles.
- Simultaneous inst read (`0xBFC0_0004`) and data write (`0x8000_0010`, wen `4'hF`, wdata `0xDEAD_BEEF`):
  - Data is issued first, then inst.
  - `stallreq` high 4 cycles.
  - `data_sram_rdata` unchanged.
- Inst read with `mem_ack` delayed 5 cycles:
  - `mem_req`, `mem_addr` and `mem_wen` stable for all 6 cycles.
  - rdata captured only at ack.
- `TIMEOUT_CYC=4`, no ack:
  - `mem_err` pulses once, 4 cycles after `mem_req` rises.
  - `inst_sram_rdata=0`.
  - `stallreq` drops the next cycle.
- `rst` asserted mid-DATA:
  - `mem_req` 0 after the reset edge, all outputs at reset values.
  - A stray `mem_ack` is ignored.
- Two consecutive pipeline cycles with inst enabled:
  - Done flags clear when `stallreq=0`.
  - Second fetch issues a new `mem_req` without a duplicate access.

Source files
------------

// File: rtl/sram_arbiter.sv
// Serialises IF and MEM SRAM requests onto one shared memory port, data first,
// with a stall request and an ack watchdog. Optional macro: SRAM_ARB_ADDR_MAP_EN.
module sram_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stallreq,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } state_e;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 32'd1);

    state_e      state_q, state_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_done_q, inst_done_d;
    logic        data_done_q, data_done_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        stall_s;

    // The address is translated when latched so mem_addr is driven straight from a flop.
    function automatic logic [31:0] map_addr(input logic [31:0] vaddr);
`ifdef SRAM_ARB_ADDR_MAP_EN
        if (vaddr[31:30] == 2'b10) begin
            return {3'b000, vaddr[28:0]};
        end else begin
            return vaddr;
        end
`else
        return vaddr;
`endif
    endfunction

    assign stall_s = (inst_sram_en & ~inst_done_q) | (data_sram_en & ~data_done_q);

    // Next-state logic: request selection, ack/timeout handling and done-flag bookkeeping.
    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        wdog_d       = wdog_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_sram_en && !data_done_q) begin
                    state_d = ST_DATA;
                    wen_d   = data_sram_wen;
                    addr_d  = map_addr(data_sram_addr);
                    wdata_d = data_sram_wdata;
                end else if (inst_sram_en && !inst_done_q) begin
                    state_d = ST_INST;
                    wen_d   = inst_sram_wen;
                    addr_d  = map_addr(inst_sram_addr);
                    wdata_d = inst_sram_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA, ST_INST: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    wdog_d  = 8'd0;
                    if (state_q == ST_DATA) begin
                        data_done_d = 1'b1;
                        if (wen_q == 4'd0) begin
                            data_rdata_d = mem_rdata;
                        end else begin
                            data_rdata_d = data_rdata_q;
                        end
                    end else begin
                        inst_done_d = 1'b1;
                        if (wen_q == 4'd0) begin
                            inst_rdata_d = mem_rdata;
                        end else begin
                            inst_rdata_d = inst_rdata_q;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    // Abandoned access: report it and hand back zero data so the pipeline can move on.
                    state_d = ST_IDLE;
                    wdog_d  = 8'd0;
                    err_d   = 1'b1;
                    if (state_q == ST_DATA) begin
                        data_done_d  = 1'b1;
                        data_rdata_d = 32'd0;
                    end else begin
                        inst_done_d  = 1'b1;
                        inst_rdata_d = 32'd0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wdog_d  = 8'd0;
            end
        endcase

        // A pipeline advance starts a fresh cycle; it overrides any completion on the same edge.
        if (!stall_s) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end else begin
            inst_done_d = inst_done_d;
            data_done_d = data_done_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wen_q        <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            wdog_q       <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
        end
    end

    assign mem_req         = (state_q != ST_IDLE);
    assign mem_wen         = wen_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign mem_err         = err_q;
    assign stallreq        = stall_s;

endmodule
